// File: rtl/sp_round_ctrl.sv
// Feistel round sequencer over four 16-bit words: result ROUNDS+1 cycles after accept, held until out_ready.
// Input is refused while a block is in flight; define SP_DECRYPT_EN to add a dec input for inverse rounds.
module sp_round_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
`ifdef SP_DECRYPT_EN
    input  logic        dec,
`endif
    input  logic [47:0] round_key,
    output logic [5:0]  round_idx,
    output logic [47:0] pbox_data,
    input  logic [15:0] f_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    fsm_t        r_fsm;
    logic [63:0] r_blk;
    logic [5:0]  r_cnt;
    logic        r_dec;
    logic        r_in_rdy;
    logic        r_out_vld;

    logic        w_dec_in;
    logic [5:0]  w_first_idx;
    logic        w_last;
    logic [5:0]  w_cnt_next;
    logic [47:0] w_mix;
    logic [63:0] w_next;

`ifdef SP_DECRYPT_EN
    assign w_dec_in = dec;
`else
    assign w_dec_in = 1'b0;
`endif

    // The counter is the round index itself: it runs down when decrypting so keys come out in reverse.
    assign w_first_idx = w_dec_in ? LAST : 6'd0;
    assign w_last      = r_dec ? (r_cnt == 6'd0) : (r_cnt == LAST);
    assign w_cnt_next  = r_dec ? (r_cnt - 6'd1) : (r_cnt + 6'd1);

    assign w_mix  = r_dec ? r_blk[63:16] : r_blk[47:0];
    assign w_next = r_dec ? {r_blk[15:0] ^ f_in, r_blk[63:16]}
                          : {r_blk[47:0], r_blk[63:48] ^ f_in};

    assign pbox_data = (r_fsm == RUN) ? (w_mix ^ round_key) : 48'd0;
    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign round_idx = r_cnt;
    assign out_block = r_out_vld ? r_blk : 64'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= IDLE;
            r_blk     <= 64'd0;
            r_cnt     <= 6'd0;
            r_dec     <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_fsm    <= RUN;
                        r_blk    <= in_block;
                        r_dec    <= w_dec_in;
                        r_cnt    <= w_first_idx;
                        r_in_rdy <= 1'b0;
                    end
                end
                RUN: begin
                    r_blk <= w_next;
                    // Counter stops on the final round so round_idx keeps showing it afterwards.
                    if (w_last) begin
                        r_fsm     <= DONE;
                        r_out_vld <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm     <= IDLE;
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_round_ctrl.sv
// Self-checking bench for sp_round_ctrl: a 32-round and a 4-round instance, randomized blocks/keys
// compared against a word-level Feistel model driven by the same environment f-function and key schedule.
module tb_sp_round_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    int          f_mode;   // 0: f_in=0, 1: f_in=FFFF, 2: environment S/P function
    bit          k_ones;   // round key forced to all ones
    logic [47:0] ks_base;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_block, a_out_block;
    logic [47:0] a_round_key, a_pbox;
    logic [5:0]  a_round_idx;
    logic [15:0] a_f_in;
`ifdef SP_DECRYPT_EN
    logic        a_dec;
    logic        b_dec;
`endif

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_block, b_out_block;
    logic [47:0] b_round_key, b_pbox;
    logic [5:0]  b_round_idx;
    logic [15:0] b_f_in;

    function automatic logic [47:0] key_of(input logic [5:0] idx, input logic [47:0] base);
        logic [47:0] m;
        m = {42'd0, idx} * 48'h9E37_79B9_7F4A;
        return base ^ m ^ {idx, 42'd0};
    endfunction

    function automatic logic [15:0] f_of(input logic [47:0] x);
        logic [15:0] a, b, c;
        a = x[47:32];
        b = x[31:16];
        c = x[15:0];
        return (a ^ {b[10:0], b[15:11]}) + (c ^ 16'h5A3C);
    endfunction

    function automatic logic [15:0] f_sel(input int mode, input logic [47:0] x);
        if (mode == 0) return 16'h0000;
        if (mode == 1) return 16'hFFFF;
        return f_of(x);
    endfunction

    assign a_round_key = k_ones ? 48'hFFFF_FFFF_FFFF : key_of(a_round_idx, ks_base);
    assign b_round_key = k_ones ? 48'hFFFF_FFFF_FFFF : key_of(b_round_idx, ks_base);
    assign a_f_in      = f_sel(f_mode, a_pbox);
    assign b_f_in      = f_sel(f_mode, b_pbox);

    sp_round_ctrl #(.ROUNDS(32)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_block(a_in_block),
`ifdef SP_DECRYPT_EN
        .dec(a_dec),
`endif
        .round_key(a_round_key), .round_idx(a_round_idx), .pbox_data(a_pbox), .f_in(a_f_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block)
    );

    sp_round_ctrl #(.ROUNDS(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
`ifdef SP_DECRYPT_EN
        .dec(b_dec),
`endif
        .round_key(b_round_key), .round_idx(b_round_idx), .pbox_data(b_pbox), .f_in(b_f_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block)
    );

    // Word-level reference: rounds applied to an array of four 16-bit words.
    function automatic logic [63:0] model(input logic [63:0] blk, input int rounds, input bit dec);
        logic [15:0] w[4];
        logic [15:0] t;
        logic [47:0] k, p;
        int idx;
        for (int i = 0; i < 4; i++) w[i] = blk[63-16*i -: 16];
        for (int r = 0; r < rounds; r++) begin
            idx = dec ? (rounds - 1 - r) : r;
            k   = k_ones ? 48'hFFFF_FFFF_FFFF : key_of(6'(idx), ks_base);
            if (!dec) begin
                p = {w[1], w[2], w[3]} ^ k;
                t = w[0] ^ f_sel(f_mode, p);
                w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = t;
            end else begin
                p = {w[0], w[1], w[2]} ^ k;
                t = w[3] ^ f_sel(f_mode, p);
                w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = t;
            end
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Offers one block to instance A and waits for its result; lat counts edges after the accepting edge.
    task automatic run_a(input logic [63:0] blk, input bit dec,
                         output logic [63:0] res, output logic [63:0] exp, output int lat);
        int guard;
        guard = 0;
        exp   = model(blk, 32, dec);
        while (a_in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        a_in_block = blk;
`ifdef SP_DECRYPT_EN
        a_dec = dec;
`endif
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = a_out_block;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++;
        if (a_pbox !== 48'd0) begin n_errors++; $display("FAIL reset_pbox: got %h want 0", a_pbox); end
        n_checks++;
        if (a_round_idx !== 6'd0) begin n_errors++; $display("FAIL reset_round_idx: got %0d want 0", a_round_idx); end
        n_checks++;
        if (a_out_block !== 64'd0) begin n_errors++; $display("FAIL reset_out_block: got %h want 0", a_out_block); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle_out_valid: got %b/%b want 0/0", a_out_valid, b_out_valid);
        end
    endtask

    // f_in = 0 makes every round a pure word rotation; 32 rounds rotate back to the input.
    task automatic test_identity();
        logic [63:0] res, exp;
        int lat;
        f_mode = 0; k_ones = 1'b0; ks_base = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        run_a(64'h0123_4567_89AB_CDEF, 1'b0, res, exp, lat);
        n_checks++;
        if (res !== 64'h0123_4567_89AB_CDEF) begin
            n_errors++; $display("FAIL identity_block: got %h want 0123456789abcdef", res);
        end
        // The accepting cycle is cycle 1, so out_valid is first seen in cycle 33 = 32 edges later.
        n_checks++;
        if (lat != 32) begin n_errors++; $display("FAIL identity_latency: got %0d edges want 32", lat); end
    endtask

    task automatic test_rounds4();
        int lat;
        f_mode = 1; k_ones = 1'b0;
        b_in_block = 64'h0123_4567_89AB_CDEF;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (b_out_block !== 64'hFEDC_BA98_7654_3210) begin
            n_errors++; $display("FAIL rounds4_block: got %h want fedcba9876543210", b_out_block);
        end
        n_checks++;
        if (lat != 4) begin n_errors++; $display("FAIL rounds4_latency: got %0d edges want 4", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_pbox_key();
        int bad_p, bad_i, guard;
        f_mode = 0; k_ones = 1'b1;
        bad_p = 0; bad_i = 0;
        a_out_ready = 1'b0;
        a_in_block  = 64'd0;
        a_in_valid  = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (a_pbox !== 48'hFFFF_FFFF_FFFF) begin
                n_errors++; bad_p++;
                if (bad_p < 4) $display("FAIL pbox_run[%0d]: got %h want ffffffffffff", i, a_pbox);
            end
            n_checks++;
            if (a_round_idx !== 6'(i)) begin
                n_errors++; bad_i++;
                if (bad_i < 4) $display("FAIL round_idx_run[%0d]: got %0d want %0d", i, a_round_idx, i);
            end
            @(posedge clk); #1;
        end
        guard = 0;
        while (a_out_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
        n_checks++;
        if (a_out_valid !== 1'b1 || a_pbox !== 48'd0 || a_round_idx !== 6'd31) begin
            n_errors++;
            $display("FAIL done_outputs: out_valid=%b pbox=%h round_idx=%0d want 1/0/31", a_out_valid, a_pbox, a_round_idx);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] blk, snap, exp, res;
        int guard, lat;
        f_mode = 2; k_ones = 1'b0; ks_base = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        blk = {$urandom, $urandom};
        exp = model(blk, 32, 1'b0);
        a_out_ready = 1'b0;
        a_in_block  = blk;
        a_in_valid  = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        guard = 0;
        while (a_out_valid !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
        snap = a_out_block;
        n_checks++;
        if (snap !== exp) begin n_errors++; $display("FAIL bp_result: got %h want %h", snap, exp); end
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin a_in_block = ~blk; a_in_valid = 1'b1; end
            if (c == 5) a_in_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_block !== snap || a_in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_block=%h in_ready=%b want 1/%h/0",
                         c, a_out_valid, a_out_block, a_in_ready, snap);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_block !== 64'd0 || a_in_ready !== 1'b1 || a_round_idx !== 6'd31) begin
            n_errors++;
            $display("FAIL bp_release: out_valid=%b out_block=%h in_ready=%b round_idx=%0d want 0/0/1/31",
                     a_out_valid, a_out_block, a_in_ready, a_round_idx);
        end
        run_a({$urandom, $urandom}, 1'b0, res, exp, lat);
        n_checks++;
        if (res !== exp || lat != 32) begin
            n_errors++; $display("FAIL bp_next_block: got %h lat %0d want %h lat 32", res, lat, exp);
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] res, exp;
        int guard, lat, seen;
        f_mode = 2; k_ones = 1'b0;
        a_in_block = {$urandom, $urandom};
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        guard = 0;
        while (a_round_idx !== 6'd7 && guard < 50) begin @(posedge clk); #1; guard++; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_round_idx !== 6'd0 || a_pbox !== 48'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b round_idx=%0d pbox=%h want 0/1/0/0",
                     a_out_valid, a_in_ready, a_round_idx, a_pbox);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin n_errors++; $display("FAIL midrun_in_ready: got %b want 1", a_in_ready); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL midrun_no_pulse: out_valid seen %0d cycles want 0", seen); end
        run_a({$urandom, $urandom}, 1'b0, res, exp, lat);
        n_checks++;
        if (res !== exp || lat != 32) begin
            n_errors++; $display("FAIL midrun_next_block: got %h lat %0d want %h lat 32", res, lat, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, exp;
        int lat;
        f_mode = 2; k_ones = 1'b0;
        for (int n = 0; n < 8; n++) begin
            ks_base = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            run_a({$urandom, $urandom}, 1'b0, res, exp, lat);
            n_checks++;
            if (res !== exp || lat != 32) begin
                n_errors++; $display("FAIL b2b[%0d]: got %h lat %0d want %h lat 32", n, res, lat, exp);
            end
        end
    endtask

`ifdef SP_DECRYPT_EN
    task automatic test_decrypt();
        logic [63:0] ct, pt, exp;
        int lat;
        f_mode = 2; k_ones = 1'b0; ks_base = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        run_a(64'h0123_4567_89AB_CDEF, 1'b0, ct, exp, lat);
        n_checks++;
        if (ct !== exp) begin n_errors++; $display("FAIL dec_encrypt: got %h want %h", ct, exp); end
        run_a(ct, 1'b1, pt, exp, lat);
        n_checks++;
        if (pt !== 64'h0123_4567_89AB_CDEF || lat != 32) begin
            n_errors++; $display("FAIL dec_roundtrip: got %h lat %0d want 0123456789abcdef lat 32", pt, lat);
        end
    endtask
`endif

    initial begin
        f_mode = 0; k_ones = 1'b0; ks_base = 48'd0;
        a_in_valid = 1'b0; a_in_block = 64'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_block = 64'd0; b_out_ready = 1'b1;
`ifdef SP_DECRYPT_EN
        a_dec = 1'b0; b_dec = 1'b0;
`endif
        test_reset();
        test_identity();
        test_rounds4();
        test_pbox_key();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
`ifdef SP_DECRYPT_EN
        test_decrypt();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
